updown_sequencer: RTL and testbench

- Command-driven controller for the sync-load up/down counter (MC10E136-style).
- Accepts a count request over a valid/ready handshake and presets the counter with that count.
- Drives the counter's mode pins to count down and stops it exactly at 0, using the counter's clout/cout lookahead outputs.
- Reports completion; supports pause and abort. Used as a programmable delay/loop timer.

---
 rtl/updown_sequencer.sv | 143 ++++++++++++++
 tb/tb_updown_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/updown_sequencer.sv
// Command-driven controller for a sync-load up/down counter: presets it, counts it down to zero, flags done.
// Optional periodic mode under `define UDSEQ_AUTORELOAD_EN adds the `reload` input.
module updown_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_count,
  input  logic             pause,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       cnt_mode,
  output logic [WIDTH-1:0] cnt_preset,
  input  logic             cnt_cout,
  input  logic             cnt_clout
`ifdef UDSEQ_AUTORELOAD_EN
  ,
  input  logic             reload
`endif
);

  localparam logic [1:0] MODE_PRESET = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LAST,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       cnt_mode_q, cnt_mode_d;
  logic [WIDTH-1:0] cnt_preset_q, cnt_preset_d;
  logic             err_q, err_d;
`ifdef UDSEQ_AUTORELOAD_EN
  logic             periodic_q, periodic_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_mode_q   <= MODE_HOLD;
      cnt_preset_q <= '0;
      err_q        <= 1'b0;
`ifdef UDSEQ_AUTORELOAD_EN
      periodic_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_mode_q   <= cnt_mode_d;
      cnt_preset_q <= cnt_preset_d;
      err_q        <= err_d;
`ifdef UDSEQ_AUTORELOAD_EN
      periodic_q   <= periodic_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_mode_d   = cnt_mode_q;
    cnt_preset_d = cnt_preset_q;
    err_d        = err_q;
`ifdef UDSEQ_AUTORELOAD_EN
    periodic_d   = periodic_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_mode_d = MODE_HOLD;
        if (cmd_valid) begin
          cnt_preset_d = cmd_count;
          cnt_mode_d   = MODE_PRESET;
          state_d      = S_LOAD;
`ifdef UDSEQ_AUTORELOAD_EN
          periodic_d   = reload;
`endif
        end
      end
      // The counter loads cnt_preset at the edge leaving LOAD, so the first decrement is requested here.
      S_LOAD: begin
        if (abort) begin
          cnt_mode_d = MODE_HOLD;
          state_d    = S_IDLE;
        end else if (cnt_preset_q == '0) begin
          cnt_mode_d = MODE_HOLD;
          state_d    = S_DONE;
        end else if (cnt_preset_q == WIDTH'(1)) begin
          cnt_mode_d = MODE_DOWN;
          state_d    = S_LAST;
        end else begin
          cnt_mode_d = pause ? MODE_HOLD : MODE_DOWN;
          state_d    = S_RUN;
        end
      end
      S_LAST: begin
        cnt_mode_d = MODE_HOLD;
        state_d    = abort ? S_IDLE : S_DONE;
      end
      // clout stays asserted while the counter holds, so it only marks the final step when decrementing.
      S_RUN: begin
        if (abort) begin
          cnt_mode_d = MODE_HOLD;
          state_d    = S_IDLE;
        end else if (cnt_mode_q == MODE_DOWN && cnt_clout) begin
          cnt_mode_d = MODE_HOLD;
          state_d    = S_DONE;
        end else begin
          cnt_mode_d = pause ? MODE_HOLD : MODE_DOWN;
        end
      end
      S_DONE: begin
        cnt_mode_d = MODE_HOLD;
        state_d    = S_IDLE;
        if (cnt_preset_q != '0 && !cnt_cout) err_d = 1'b1;
`ifdef UDSEQ_AUTORELOAD_EN
        if (periodic_q) begin
          cnt_mode_d = MODE_PRESET;
          state_d    = S_LOAD;
        end
`endif
      end
      default: begin
        cnt_mode_d = MODE_HOLD;
        state_d    = S_IDLE;
      end
    endcase
  end

  assign cnt_mode   = cnt_mode_q;
  assign cnt_preset = cnt_preset_q;
  assign err        = err_q;
  assign busy       = (state_q != S_IDLE);
  assign cmd_ready  = (state_q == S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_updown_sequencer.sv
// Directed bench for updown_sequencer with a behavioural model of the sync-load up/down counter.
module tb_updown_sequencer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_count = '0;
  logic             pause = 1'b0;
  logic             abort = 1'b0;
  logic             busy, done, err;
  logic [1:0]       cnt_mode;
  logic [WIDTH-1:0] cnt_preset;
  logic             cnt_cout, cnt_clout;
`ifdef UDSEQ_AUTORELOAD_EN
  logic             reload = 1'b0;
`endif

  updown_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_count(cmd_count), .pause(pause), .abort(abort), .busy(busy),
    .done(done), .err(err), .cnt_mode(cnt_mode), .cnt_preset(cnt_preset),
    .cnt_cout(cnt_cout), .cnt_clout(cnt_clout)
`ifdef UDSEQ_AUTORELOAD_EN
    , .reload(reload)
`endif
  );

  always #5 clk = ~clk;

  // Counter model: lookahead flags are valid only after a decrement and are held through hold cycles.
  logic [WIDTH-1:0] out_m = '0;
  logic             dec_m = 1'b0;
  logic             force_cout_lo = 1'b0;
  int               edge_cnt = 0;
  int               dec_edges = 0;
  int               done_cnt = 0;

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (cnt_mode == 2'b01) dec_edges <= dec_edges + 1;
    if (done) done_cnt <= done_cnt + 1;
    case (cnt_mode)
      2'b00: begin out_m <= cnt_preset; dec_m <= 1'b0; end
      2'b01: begin out_m <= out_m - 1'b1; dec_m <= 1'b1; end
      2'b10: begin out_m <= out_m + 1'b1; dec_m <= 1'b0; end
      default: ;
    endcase
  end

  assign cnt_cout  = (out_m == '0) && dec_m && !force_cout_lo;
  assign cnt_clout = (out_m == WIDTH'(1)) && dec_m;

  int n_checks = 0;
  int n_fail   = 0;
  int e0, d0, k0, at;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input int n);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_count = WIDTH'(n);
    @(negedge clk);
    cmd_valid = 1'b0;
    e0 = edge_cnt;
    d0 = dec_edges;
    k0 = done_cnt;
  endtask

  task automatic wait_done(input int limit, output int at_edge);
    at_edge = -1;
    for (int i = 0; i < limit; i++) begin
      if (done) begin
        at_edge = edge_cnt;
        break;
      end
      @(negedge clk);
    end
    if (at_edge < 0) check("done_timeout", 0, 1);
  endtask

  task automatic run_plain(input string tag, input int n);
    issue(n);
    wait_done(n + 20, at);
    check({tag, "_latency"}, at - e0, (n == 0) ? 1 : n + 1);
    @(negedge clk);
    check({tag, "_dec_edges"}, dec_edges - d0, n);
    check({tag, "_out"}, int'(out_m), 0);
    check({tag, "_done_pulses"}, done_cnt - k0, 1);
    check({tag, "_mode_after"}, int'(cnt_mode), 3);
    check({tag, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    check("rst_mode", int'(cnt_mode), 3);
    check("rst_preset", int'(cnt_preset), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(cmd_ready), 1);
    @(negedge clk);
    reset = 1'b1;

    run_plain("n5", 5);
    check("n5_err", int'(err), 0);
    run_plain("n0", 0);
    run_plain("n1", 1);
    check("n1_err", int'(err), 0);
    run_plain("n255", 255);

    // Pause sampled at three edges starting with the first decrement: counter parks at 3.
    issue(4);
    @(negedge clk);
    pause = 1'b1;
    repeat (3) @(negedge clk);
    check("pause_hold_out", int'(out_m), 3);
    check("pause_hold_mode", int'(cnt_mode), 3);
    pause = 1'b0;
    wait_done(40, at);
    check("pause_latency", at - e0, 4 + 1 + 3);
    @(negedge clk);
    check("pause_dec_edges", dec_edges - d0, 4);
    check("pause_out", int'(out_m), 0);

    // Abort sampled at the fourth decrement edge.
    issue(10);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_out", int'(out_m), 6);
    check("abort_mode", int'(cnt_mode), 3);
    check("abort_ready", int'(cmd_ready), 1);
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt - k0, 0);
    check("abort_out_held", int'(out_m), 6);

    // Asynchronous reset mid-RUN.
    issue(20);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_mode", int'(cnt_mode), 3);
    check("arst_preset", int'(cnt_preset), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_ready", int'(cmd_ready), 1);
    @(negedge clk);
    reset = 1'b1;

    // Lookahead failure: cout suppressed while DONE samples it.
    force_cout_lo = 1'b1;
    issue(3);
    wait_done(20, at);
    check("la_latency", at - e0, 4);
    @(negedge clk);
    force_cout_lo = 1'b0;
    check("la_err_set", int'(err), 1);
    run_plain("la_next", 2);
    check("la_err_sticky", int'(err), 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("la_err_reset", int'(err), 0);
    @(negedge clk);
    reset = 1'b1;

`ifdef UDSEQ_AUTORELOAD_EN
    reload = 1'b1;
    issue(3);
    reload = 1'b0;
    wait_done(20, at);
    check("ar_first", at - e0, 4);
    for (int p = 0; p < 2; p++) begin
      int prev;
      prev = at;
      @(negedge clk);
      check("ar_busy", int'(busy), 1);
      wait_done(20, at);
      check("ar_period", at - prev, 5);
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ar_abort_busy", int'(busy), 0);
    check("ar_abort_ready", int'(cmd_ready), 1);
    repeat (8) @(negedge clk);
    check("ar_stopped", int'(busy), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
